// File: rtl/enc_round_last.sv
// AES final encryption round (SubBytes, ShiftRows, AddRoundKey) as a 2-stage valid/ready pipeline.
// Optional macro ENC_ROUND_LAST_KEY_CHECK_EN blocks input until a round key has been loaded.
module enc_round_last #(
  parameter logic [3:0] ADDRESS = 4'd10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] rkey,
  input  logic [3:0]   addr,
  input  logic         key_we,
  input  logic [127:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [127:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready
);

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    sub_bytes = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sub_bytes[8*i +: 8] = sbox(s[8*i +: 8]);
    end
  endfunction

  // Byte k = 4*col + row sits at bits [127-8k -: 8]; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    shift_rows = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shift_rows[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
  endfunction

  logic         v1_q, v1_d;
  logic         v2_q, v2_d;
  logic [127:0] s1_q, s1_d;
  logic [127:0] dout_q, dout_d;
  logic [127:0] key_q, key_d;
  logic         key_hit;
  logic         adv1, adv2, in_ok, accept;

  assign key_hit = key_we && (addr == ADDRESS);

`ifdef ENC_ROUND_LAST_KEY_CHECK_EN
  logic key_loaded_q, key_loaded_d;

  always_comb begin
    key_loaded_d = key_loaded_q | key_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) key_loaded_q <= 1'b0;
    else     key_loaded_q <= key_loaded_d;
  end

  assign in_ok = key_loaded_q;
`else
  assign in_ok = 1'b1;
`endif

  assign adv2   = !v2_q || dout_ready;
  assign adv1   = !v1_q || adv2;
  assign accept = din_valid && din_ready;

  always_comb begin
    v1_d   = v1_q;
    s1_d   = s1_q;
    v2_d   = v2_q;
    dout_d = dout_q;
    key_d  = key_hit ? rkey : key_q;
    if (adv1) begin
      v1_d = accept;
      if (accept) s1_d = sub_bytes(din);
    end
    // Capture uses key_q, so a same-edge key write only affects later blocks.
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) dout_d = shift_rows(s1_q) ^ key_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s1_q   <= '0;
      dout_q <= '0;
      key_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      s1_q   <= s1_d;
      dout_q <= dout_d;
      key_q  <= key_d;
    end
  end

  assign din_ready  = adv1 && in_ok && !rst;
  assign dout_valid = v2_q && !rst;
  assign dout       = dout_q;

endmodule

// File: tb/tb_enc_round_last.sv
// Scoreboard bench for enc_round_last: directed vectors pushed on accept, monitor pops on output handshake.
module tb_enc_round_last;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] rkey = '0;
  logic [3:0]   addr = '0;
  logic         key_we = 1'b0;
  logic [127:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [127:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b1;

  enc_round_last #(.ADDRESS(4'd10)) dut (
    .clk(clk), .rst(rst), .rkey(rkey), .addr(addr), .key_we(key_we),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_IN  = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [127:0] B_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
  // Hand-copied S(0x00)..S(0x0f).
  logic [7:0] SB [16] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                          8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};

  typedef struct {
    logic [127:0] data;
    int           acc;
    bit           chk;
  } exp_t;
  exp_t sq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic         hold_pend = 1'b0;
  logic [127:0] hold_val  = '0;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 128'(dout_valid), 128'd1);
        check("hold_data", dout, hold_val);
      end
      if (dout_valid && dout_ready) begin
        if (sq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h want none", dout);
        end else begin
          check("dout", dout, sq[0].data);
          if (sq[0].chk) check("latency", 128'(cyc - sq[0].acc), 128'd2);
          void'(sq.pop_front());
        end
      end
      hold_pend <= dout_valid && !dout_ready;
      hold_val  <= dout;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [127:0] d, input logic [127:0] e, input bit chk);
    bit ok = 1'b0;
    din = d;
    din_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = din_ready;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got din_ready=0 want 1 within 50 cycles");
      din_valid = 1'b0;
    end else begin
      sq.push_back('{data: e, acc: cyc, chk: chk});
      @(posedge clk); #1;
      din_valid = 1'b0;
    end
  endtask

  task automatic wkey(input logic [3:0] a, input logic [127:0] k);
    addr = a;
    rkey = k;
    key_we = 1'b1;
    @(posedge clk); #1;
    key_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bv;
    din_valid = 1'b1;
    key_we = 1'b1;
    addr = 4'd10;
    rkey = '1;
    din = B_IN;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_din_ready", 128'(din_ready), 128'd0);
    check("rst_dout_valid", 128'(dout_valid), 128'd0);
    check("rst_dout", dout, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    key_we = 1'b0;
`ifdef ENC_ROUND_LAST_KEY_CHECK_EN
    @(negedge clk);
    check("nokey_din_ready", 128'(din_ready), 128'd0);
    @(posedge clk); #1;
    din_valid = 1'b0;
`else
    din_valid = 1'b0;
    @(negedge clk);
    check("post_rst_din_ready", 128'(din_ready), 128'd1);
    @(posedge clk); #1;
`endif
    wkey(4'd10, KEY);
    @(negedge clk);
    check("key_din_ready", 128'(din_ready), 128'd1);
    @(posedge clk); #1;

    send(B_IN, B_OUT, 1'b1);
    wkey(4'd9, 128'hffffffffffffffffffffffffffffffff);
    send(B_IN, B_OUT, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    for (int b = 0; b < 8; b++) begin
      bv = 8'(b);
      send({16{bv}}, {16{SB[b]}} ^ KEY, 1'b1);
    end
    repeat (3) @(posedge clk);
    #1;

    // Key write on the same edge as stage-2 capture of the first block.
    send('0, {16{8'h63}} ^ KEY, 1'b1);
    wkey(4'd10, '0);
    send('0, {16{8'h63}}, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    fork
      begin
        for (int b = 8; b < 16; b++) begin
          bv = 8'(b);
          send({16{bv}}, {16{SB[b]}}, 1'b0);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        dout_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_din_ready", 128'(din_ready), 128'd0);
        end
        @(posedge clk); #1;
        dout_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    dout_ready = 1'b0;
    send(128'h0123456789abcdef0123456789abcdef, '0, 1'b0);
    send(128'hfedcba9876543210fedcba9876543210, '0, 1'b0);
    sq.delete();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dout_valid", 128'(dout_valid), 128'd0);
    check("midrst_din_ready", 128'(din_ready), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    check("after_rst_dout_valid", 128'(dout_valid), 128'd0);
    check("after_rst_dout", dout, 128'd0);
`ifdef ENC_ROUND_LAST_KEY_CHECK_EN
    check("after_rst_din_ready", 128'(din_ready), 128'd0);
`else
    check("after_rst_din_ready", 128'(din_ready), 128'd1);
`endif
    repeat (6) @(posedge clk);
    #1;
    check("queue_empty", 128'(sq.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enc_round_last.md
ENC_ROUND_LAST -- requirements
Module: enc_round_last

Interface
REQ-001 SHALL have parameter ADDRESS, default 4'd10, the round-key slot index this round accepts.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rkey  input  128  round-key write data.
REQ-005 SHALL have port addr  input  4  round-key write slot index.
REQ-006 SHALL have port key_we  input  1  round-key write strobe.
REQ-007 SHALL have port din  input  128  state in; byte din[127:120] = s(0,0), column-major per FIPS-197.
REQ-008 SHALL have port din_valid  input  1  din holds a block.
REQ-009 SHALL have port din_ready  output  1  block accepted when din_valid and din_ready are both high.
REQ-010 SHALL have port dout  output  128  ciphertext block, same byte order as din.
REQ-011 SHALL have port dout_valid  output  1  dout holds a block.
REQ-012 SHALL have port dout_ready  input  1  consumer takes dout when dout_valid and dout_ready are both high.

Function
REQ-013 SHALL compute final encryption round: dout = AddRoundKey(ShiftRows(SubBytes(din)), key_reg); no MixColumns.
REQ-014 SHALL load key_reg <= rkey on a clock edge when key_we=1 and addr==ADDRESS; other addr values ignored.
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers SubBytes(din) with flag v1; stage 2 registers ShiftRows(stage1) XOR key_reg with flag v2.
REQ-016 SHALL hold latency of exactly 2 cycles, accept to dout_valid, when no stall occurs.
REQ-017 SHALL sustain throughput of 1 block/cycle while dout_ready=1.
REQ-018 SHALL advance stage 2 when v2=0 or dout_ready=1.
REQ-019 SHALL advance stage 1 when v1=0 or stage 2 advances; din_ready SHALL equal that stage-1 advance condition, combinationally.
REQ-020 SHALL fill a bubble: with v2=0 and v1=1, stage 2 captures even when dout_ready=0.
REQ-021 SHALL hold dout and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-022 SHALL, on a key write in the same cycle as a stage-2 capture, use the old key_reg value for that capture; the new key applies from the next capture.
REQ-023 SHALL require no AES-side handling of a key change mid-flight; blocks already in stage 2 keep their captured result.
REQ-024 SHALL implement SubBytes as 16 parallel forward S-box lookups, ShiftRows as fixed wiring: row r rotates left by r bytes.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear v1, v2, key_reg, the stage-1 data register and dout to zero.
REQ-026 SHALL, during rst=1, drop any in-flight block and hold din_ready=0, dout_valid=0; din_valid and key_we are ignored.
REQ-027 SHALL have din_ready=1 on the first cycle after rst falls, subject to REQ-029.

Configuration
REQ-028 SHALL, without macro ENC_ROUND_LAST_KEY_CHECK_EN, behave as REQ-013 to REQ-027 with no key-loaded tracking.
REQ-029 SHALL, with ENC_ROUND_LAST_KEY_CHECK_EN defined, add a key_loaded flag; reset clears it, a REQ-014 write sets it, and din_ready is forced to 0 while it is 0.

Verification
REQ-030 SHALL cover the FIPS-197 App. B vector: write key d014f9a8c9ee2589e13f0cc8b6630ca6 at addr 10, then send din eb40f21e592e38848ba113e71bc342d2 -> dout 3925841d02dc09fbdc118597196a0b32 with dout_valid exactly 2 cycles after accept.
REQ-031 SHALL cover a key write at addr 9 with ADDRESS=10 -> key_reg unchanged; the REQ-030 block still yields 3925841d... .
REQ-032 SHALL cover 8 back-to-back blocks with dout_ready=1 -> 8 consecutive dout_valid cycles, in order; then dout_ready=0 for 3 cycles mid-stream -> dout held, din_ready=0 once both stages are full, no block lost or duplicated.
REQ-033 SHALL cover rst asserted for 1 cycle with both stages full -> v1=v2=0 and dout=0 next cycle; no stale output after release.
REQ-034 SHALL cover, with ENC_ROUND_LAST_KEY_CHECK_EN defined, din_valid=1 after reset without a key write -> din_ready=0; after the addr-10 key write, din_ready=1 on the next cycle.
